// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// register-address width, default multiply latency and a saturating helper.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W     = 3;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) r = v;
    else                    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags when the instruction in ID
// reads the register a load in EX is about to write. Register 0 is hardwired
// to zero, so it can never carry a real dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] EX_rt,
  input  logic                  EX_MemRead,
  output logic                  hazard
);

  logic rs_match;
  logic rt_match;
  logic dest_nonzero;

  assign dest_nonzero = (EX_rt != '0);
  assign rs_match     = (EX_rt == ID_rs);
  assign rt_match     = ID_UsesRt && (EX_rt == ID_rt);
  assign hazard       = EX_MemRead && dest_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: arbitrates memory wait, multi-cycle multiply,
// taken-branch flush and load-use stall, and counts cycles in which the PC
// was frozen. Outputs are combinational from state, mul_cnt and inputs.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] EX_rt,
  input  logic                  EX_MemRead,
  input  logic                  EX_Mult,
  input  logic                  Branch_Taken,
  input  logic                  Mem_Req,
  input  logic                  Mem_Ready,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Write,
  output logic                  EX_MEM_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Bubble,
  output logic                  EX_MEM_Bubble,
  output logic                  MEM_WB_Bubble,
  output logic                  Mul_Done,
  output logic [CNT_W-1:0]      Stall_Cnt
);

  // First countdown value: the RUN cycle that accepts the multiply is itself
  // one hold cycle, and the final (count==0) cycle releases the pipeline.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

  state_t           state;
  state_t           state_nx;
  state_t           ret_st;
  state_t           ret_nx;
  state_t           eff_st;
  logic [CNT_W-1:0] mul_cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             lu_hazard;
  logic             mem_stall;

  load_use_detect u_lud (
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .ID_UsesRt  (ID_UsesRt),
    .EX_rt      (EX_rt),
    .EX_MemRead (EX_MemRead),
    .hazard     (lu_hazard)
  );

  assign mem_stall = Mem_Req && !Mem_Ready;

  // MEM_WAIT resolves as whatever state it interrupted, so the interrupted
  // operation continues seamlessly on the cycle memory becomes ready.
  assign eff_st = (state == MEM_WAIT) ? ret_st : state;

  // Next-state, counter update and pipeline control outputs.
  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MEM_WB_Bubble = 1'b0;
    Mul_Done      = 1'b0;
    state_nx      = state;
    ret_nx        = ret_st;
    cnt_nx        = mul_cnt;

    if (mem_stall) begin
      // Full freeze; the multiply countdown does not advance.
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
      ret_nx        = eff_st;
      state_nx      = MEM_WAIT;
    end else begin
      case (eff_st)
        RUN: begin
          state_nx = RUN;
          if (EX_Mult) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            cnt_nx        = MUL_LOAD;
            state_nx      = MUL_BUSY;
          end else if (Branch_Taken) begin
            // Wrong-path instructions in IF/ID are squashed, so any load-use
            // dependency they carry is moot.
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (lu_hazard) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end
        MUL_BUSY: begin
          if (mul_cnt != '0) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            cnt_nx        = mul_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            state_nx      = MUL_BUSY;
          end else begin
            Mul_Done = 1'b1;
            state_nx = RUN;
          end
        end
        default: begin
          state_nx = RUN;
        end
      endcase
    end

    // Reset forces every enable and bubble low, independent of state.
    if (rst) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Bubble  = 1'b0;
      EX_MEM_Bubble = 1'b0;
      MEM_WB_Bubble = 1'b0;
      Mul_Done      = 1'b0;
    end
  end

  // FSM state, return state and multiply countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      ret_st  <= RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_nx;
      ret_st  <= ret_nx;
      mul_cnt <= cnt_nx;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Stall_Cnt <= '0;
    end else if (!PC_Write) begin
      Stall_Cnt <= sat_inc(Stall_Cnt);
    end
  end

endmodule
